simon_serial_core: RTL

Parametrised bit-serial-I/O Simon block cipher engine, successor to the fixed Simon32/64 bit-serial core.
- Word size, key-word count, round count and z-sequence are parameters.
- The datapath runs one full round per cycle with on-the-fly key expansion.
- The loaded master key is retained across blocks, so successive plaintexts encrypt without reloading the key.
- It sits behind the Tiny Tapeout top-level wrapper, driven from ui_in, with results on uo_out.

---
 rtl/simon_serial_core.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/simon_serial_core.sv
// Bit-serial-I/O Simon block cipher engine, one full round per clock with on-the-fly key
// expansion. The master key is retained across blocks so successive plaintexts can be
// encrypted without reloading it.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   data_in    serial load bit, LSB first
//   data_rdy   command: 0 idle, 1 load plaintext, 2 load key, 3 encrypt (on rising qualify)
//   debug_port sampled at encrypt start: 0 streams ciphertext, 1 streams the master key
//   cipher_out registered serial result bit, LSB first
//   valid      high while cipher_out carries a result bit
//   busy       high while running rounds or streaming the result
module simon_serial_core #(
  parameter int unsigned WORD      = 16,
  parameter int unsigned KEY_WORDS = 4,
  parameter int unsigned ROUNDS    = 32,
  parameter logic [61:0] Z_SEQ     =
    62'b11111010001001010110000111001101111101000100101011000011100110
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       data_in,
  input  logic [1:0] data_rdy,
  input  logic       debug_port,
  output logic       cipher_out,
  output logic       valid,
  output logic       busy
);

  localparam int unsigned BlkW = 2 * WORD;
  localparam int unsigned KeyW = KEY_WORDS * WORD;
  localparam int unsigned RndW = $clog2(ROUNDS + 1);
  localparam int unsigned CntW = $clog2(KeyW + 1);

  if (KEY_WORDS < 2 || KEY_WORDS > 4) begin : g_bad_key_words
    $error("simon_serial_core: KEY_WORDS must be 2, 3 or 4");
  end

  typedef enum logic [1:0] {StIdle, StRun, StOut} state_e;

  function automatic logic [WORD-1:0] rol(input logic [WORD-1:0] v, input int unsigned s);
    return (v << s) | (v >> (WORD - s));
  endfunction

  function automatic logic [WORD-1:0] ror(input logic [WORD-1:0] v, input int unsigned s);
    return (v >> s) | (v << (WORD - s));
  endfunction

  state_e            state_q;
  logic [BlkW-1:0]   blk_q;      // {x, y}
  logic [KeyW-1:0]   key_q;      // master key, untouched by rounds
  logic [KeyW-1:0]   kwin_q;     // working key window, k0 in the low word
  logic [KeyW-1:0]   out_sr_q;
  logic [CntW-1:0]   out_cnt_q;
  logic [RndW-1:0]   rnd_q;
  logic [5:0]        zptr_q;
  logic              dbg_q;
  logic [1:0]        rdy_prev_q;

  logic [WORD-1:0] x, y, k0, k1, ktop, t, tmp, knew, x_nx;
  logic            z_bit;
  logic [BlkW-1:0] blk_nx;
  logic [KeyW-1:0] kwin_nx;

  always_comb begin
    x     = blk_q[BlkW-1:WORD];
    y     = blk_q[WORD-1:0];
    k0    = kwin_q[WORD-1:0];
    k1    = kwin_q[2*WORD-1:WORD];
    ktop  = kwin_q[KeyW-1 -: WORD];
    t     = '0;
    z_bit = Z_SEQ[6'd61 - zptr_q];
    if (KEY_WORDS == 4) begin
      t   = ror(ktop, 3) ^ k1;
      tmp = t ^ ror(t, 1);
    end else begin
      tmp = ror(ktop, 3) ^ ror(ktop, 4);
    end
    knew    = ~k0 ^ tmp ^ {{(WORD-1){1'b0}}, z_bit} ^ {{(WORD-2){1'b0}}, 2'b11};
    kwin_nx = {knew, kwin_q[KeyW-1:WORD]};
    x_nx    = y ^ (rol(x, 1) & rol(x, 8)) ^ rol(x, 2) ^ k0;
    blk_nx  = {x_nx, x};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      blk_q      <= '0;
      key_q      <= '0;
      kwin_q     <= '0;
      out_sr_q   <= '0;
      out_cnt_q  <= '0;
      rnd_q      <= '0;
      zptr_q     <= '0;
      dbg_q      <= 1'b0;
      rdy_prev_q <= '0;
      cipher_out <= 1'b0;
      valid      <= 1'b0;
      busy       <= 1'b0;
    end else begin
      // Tracked every cycle so a held encrypt command never re-triggers.
      rdy_prev_q <= data_rdy;
      unique case (state_q)
        StIdle: begin
          valid      <= 1'b0;
          cipher_out <= 1'b0;
          case (data_rdy)
            2'd1: blk_q <= {data_in, blk_q[BlkW-1:1]};
            2'd2: key_q <= {data_in, key_q[KeyW-1:1]};
            2'd3: begin
              if (rdy_prev_q != 2'd3) begin
                kwin_q  <= key_q;
                rnd_q   <= '0;
                zptr_q  <= '0;
                dbg_q   <= debug_port;
                busy    <= 1'b1;
                state_q <= StRun;
              end
            end
            default: ;
          endcase
        end
        StRun: begin
          blk_q  <= blk_nx;
          kwin_q <= kwin_nx;
          zptr_q <= (zptr_q == 6'd61) ? 6'd0 : zptr_q + 6'd1;
          rnd_q  <= rnd_q + 1'b1;
          if (rnd_q == RndW'(ROUNDS - 1)) begin
            // Load from the post-round value so the result streams right after the last round.
            out_sr_q  <= dbg_q ? key_q : KeyW'(blk_nx);
            out_cnt_q <= dbg_q ? CntW'(KeyW) : CntW'(BlkW);
            state_q   <= StOut;
          end
        end
        StOut: begin
          if (out_cnt_q != '0) begin
            cipher_out <= out_sr_q[0];
            valid      <= 1'b1;
            out_sr_q   <= out_sr_q >> 1;
            out_cnt_q  <= out_cnt_q - 1'b1;
          end else begin
            cipher_out <= 1'b0;
            valid      <= 1'b0;
            busy       <= 1'b0;
            state_q    <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
